// File: rtl/btn_debounce_pkg.sv
// btn_debounce_pkg: shared defaults and ULX3S button bit positions for btn_debounce.
package btn_debounce_pkg;
    localparam int DEBOUNCE_CYCLES_DEF = 250000;
    localparam int DEBOUNCE_CYCLES_SIM = 4;
    localparam int REPEAT_DELAY_DEF    = 12500000;
    localparam int REPEAT_PERIOD_DEF   = 2500000;
    localparam int BTN_PWR   = 0;
    localparam int BTN_F1    = 1;
    localparam int BTN_F2    = 2;
    localparam int BTN_UP    = 3;
    localparam int BTN_DOWN  = 4;
    localparam int BTN_LEFT  = 5;
    localparam int BTN_RIGHT = 6;
endpackage

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one button channel, 2-flop synchroniser, stable-count debounce, press/release strobes.
// Define BTN_DEBOUNCE_AUTOREPEAT_EN to re-strobe press while the button stays held.
module btn_debounce_ch
    import btn_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNTR_W          = 24,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic clk_25mhz,
    input  logic rst_25mhz,
    input  logic btn,
    output logic level,
    output logic press,
    output logic rel
);
    if (DEBOUNCE_CYCLES < 2 || (64'(1) << CNTR_W) <= 64'(DEBOUNCE_CYCLES) || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("btn_debounce_ch: illegal parameter combination");
    end
    logic s1, s, acc, rep;
    logic [CNTR_W-1:0] cnt;
    assign acc = (s != level) && (cnt == CNTR_W'(DEBOUNCE_CYCLES - 1));
    always_ff @(posedge clk_25mhz) begin
        if (rst_25mhz) begin
            s1 <= 1'b0;
            s  <= 1'b0;
        end else begin
            s1 <= btn;
            s  <= s1;
        end
    end
    always_ff @(posedge clk_25mhz) begin
        if (rst_25mhz) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            cnt   <= (s == level || acc) ? '0 : cnt + 1'b1;
            level <= acc ? s : level;
            press <= (acc & s) | rep;
            rel   <= acc & ~s;
        end
    end
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    localparam int RW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
    logic [RW-1:0] rcnt;
    logic rfirst;
    // rcnt counts cycles since the last press strobe; the first gap is the longer delay
    assign rep = level && !acc && rcnt == (rfirst ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1));
    always_ff @(posedge clk_25mhz) begin
        if (rst_25mhz || !level || acc) begin
            rcnt   <= '0;
            rfirst <= 1'b1;
        end else if (rep) begin
            rcnt   <= '0;
            rfirst <= 1'b0;
        end else begin
            rcnt <= rcnt + 1'b1;
        end
    end
`else
    assign rep = 1'b0;
`endif
endmodule

// File: rtl/btn_debounce.sv
// btn_debounce: synchronise and debounce N_BTN raw buttons into levels, press/release strobes and o_any.
// Define BTN_DEBOUNCE_AUTOREPEAT_EN to add press auto-repeat on held buttons.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int N_BTN           = 7,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNTR_W          = 24,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic             clk_25mhz,
    input  logic             rst_25mhz,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release,
    output logic             o_any
);
    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNTR_W         (CNTR_W),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk_25mhz(clk_25mhz),
            .rst_25mhz(rst_25mhz),
            .btn      (i_btn[i]),
            .level    (o_level[i]),
            .press    (o_press[i]),
            .rel      (o_release[i])
        );
    end
    always_ff @(posedge clk_25mhz) begin
        if (rst_25mhz) o_any <= 1'b0;
        else o_any <= |o_level;
    end
endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: randomized + directed stimulus, window-based reference model, queued scoreboard.
module tb_btn_debounce;
    import btn_debounce_pkg::*;
    localparam int N  = 7;
    localparam int D  = DEBOUNCE_CYCLES_SIM;
    localparam int RD = 10;
    localparam int RP = 3;

    logic clk_25mhz = 1'b0;
    logic rst_25mhz = 1'b1;
    logic [N-1:0] i_btn = '0;
    logic [N-1:0] o_level, o_press, o_release;
    logic o_any;

    always #20 clk_25mhz = ~clk_25mhz;

    btn_debounce #(
        .N_BTN(N), .DEBOUNCE_CYCLES(D), .CNTR_W(3), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk_25mhz(clk_25mhz),
        .rst_25mhz(rst_25mhz),
        .i_btn    (i_btn),
        .o_level  (o_level),
        .o_press  (o_press),
        .o_release(o_release),
        .o_any    (o_any)
    );

    typedef struct packed {
        logic [N-1:0] lvl;
        logic [N-1:0] prs;
        logic [N-1:0] rel;
        logic         any;
    } out_t;

    out_t exp_q[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [N-1:0] p1 = '0, p2 = '0, m_lvl = '0;
    logic [D-1:0] win[N];
    int nv[N];
    int age[N];

    always @(posedge clk_25mhz) begin : model
        out_t e;
        e = '0;
        if (rst_25mhz) begin
            p1 = '0;
            p2 = '0;
            m_lvl = '0;
            for (int c = 0; c < N; c++) begin
                win[c] = '0;
                nv[c] = 0;
                age[c] = 0;
            end
        end else begin
            e.any = |m_lvl;
            for (int c = 0; c < N; c++) begin
                win[c] = {win[c][D-2:0], p2[c]};
                if (nv[c] < D) nv[c]++;
                if (nv[c] == D && win[c] == {D{~m_lvl[c]}}) begin
                    m_lvl[c] = ~m_lvl[c];
                    e.prs[c] = m_lvl[c];
                    e.rel[c] = ~m_lvl[c];
                    age[c] = 0;
                end else if (m_lvl[c]) begin
                    age[c]++;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
                    e.prs[c] = (age[c] == RD) || (age[c] > RD && (age[c] - RD) % RP == 0);
`endif
                end
            end
            p2 = p1;
            p1 = i_btn;
        end
        e.lvl = m_lvl;
        exp_q.push_back(e);
    end

    always @(negedge clk_25mhz) begin : monitor
        out_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({o_level, o_press, o_release, o_any} !== e) begin
                failures++;
                $display("FAIL outputs cycle=%0d got lvl=%b prs=%b rel=%b any=%b expected lvl=%b prs=%b rel=%b any=%b",
                         cyc, o_level, o_press, o_release, o_any, e.lvl, e.prs, e.rel, e.any);
            end
            checks++;
            if ((o_press & o_release) !== '0) begin
                failures++;
                $display("FAIL press and release together cycle=%0d prs=%b rel=%b", cyc, o_press, o_release);
            end
        end
    end

    initial begin : watchdog
        #2ms;
        failures++;
        $display("FAIL timeout: test did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic step(input logic [N-1:0] b, input logic r);
        @(negedge clk_25mhz);
        i_btn = b;
        rst_25mhz = r;
        cyc++;
    endtask

    task automatic hold(input logic [N-1:0] b, input int n);
        repeat (n) step(b, 1'b0);
    endtask

    initial begin
        logic [N-1:0] b;
        logic [5:0] pat;
        int rem[N];
        b = '0;
        pat = 6'b101101;
        repeat (3) step('0, 1'b1);
        hold('0, 20);
        checks++;
        if ({o_level, o_press, o_release, o_any} !== '0) begin
            failures++;
            $display("FAIL reset state: lvl=%b prs=%b rel=%b any=%b", o_level, o_press, o_release, o_any);
        end
        b[2] = 1'b1;
        hold(b, 12);
        for (int i = 5; i >= 0; i--) begin
            b[0] = pat[i];
            step(b, 1'b0);
        end
        hold(b, 10);
        b[6] = 1'b1;
        hold(b, 10);
        b[0] = 1'b0;
        b[6] = 1'b0;
        hold(b, 10);
        step(b, 1'b1);
        hold(b, 10);
        b[3] = 1'b1;
        hold(b, 40);
        b = '0;
        hold(b, 12);
        for (int c = 0; c < N; c++) rem[c] = 0;
        for (int t = 0; t < 3000; t++) begin
            for (int c = 0; c < N; c++) begin
                if (rem[c] == 0) begin
                    b[c] = ~b[c];
                    rem[c] = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : $urandom_range(4, 24);
                end else begin
                    rem[c]--;
                end
            end
            step(b, $urandom_range(0, 399) == 0);
        end
        hold('0, 12);
        repeat (2) @(negedge clk_25mhz);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
